servo_frame_sched: RTL
======================

SERVO_FRAME_SCHED -- requirements
Module: servo_frame_sched

Interface
REQ-001 Parameter TICK_DIV, default 500, meaning clk cycles per timing tick (10 us at 50 MHz).
REQ-002 Parameter SLOT_TICKS, default 250, meaning ticks per channel slot (2.5 ms).
REQ-003 Parameter FRAME_TICKS, default 2000, meaning ticks per servo frame (20 ms).
REQ-004 Port clk  input  1  system clock; the single clock domain for the block.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Port wr_en  input  1  one-cycle write strobe for channel configuration.
REQ-007 Port wr_ch  input  2  channel index 0..3 addressed by the write.
REQ-008 Port wr_pos  input  3  position code 0..7 for the addressed channel.
REQ-009 Port wr_ena  input  1  channel enable written with the position.
REQ-010 Port servo  output  4  per-channel PWM outputs; bit n drives servo n.
REQ-011 Port frame_start  output  1  one-cycle pulse on the first cycle of each frame.
REQ-012 Port pending  output  1  high while any written configuration has not yet been applied.

Function
REQ-013 A prescaler SHALL count clk cycles 0..TICK_DIV-1 and assert an internal tick on the cycle the count wraps.
REQ-014 A frame counter SHALL advance on each tick, 0..FRAME_TICKS-1, and wrap to 0.
REQ-015 Each channel SHALL have a shadow register (pos, ena) written on wr_en and an active register loaded from the shadow at frame start.
REQ-016 Writes SHALL never alter the active register mid-frame; glitch-free output is mandatory.
REQ-017 Multiple writes to one channel within a frame: last write wins; writes to different channels in the same frame are all retained.
REQ-018 A write coinciding with the frame-start load cycle SHALL land in the shadow and be applied at the following frame start.
REQ-019 pending SHALL set on the cycle after wr_en and clear on the cycle after the frame-start load that consumes it, unless a new write coincides with that load.
REQ-020 State machine states: IDLE, LOAD, PULSE, GAP, REST.
REQ-021 IDLE: entered on reset; exits to LOAD on the first tick.
REQ-022 LOAD: one clk cycle; copies all shadows to active, asserts frame_start, sets slot index to 0, goes to PULSE.
REQ-023 PULSE: servo[slot] high when active ena=1; lasts W = 100 + 14*pos ticks (pos 0 -> 1.00 ms, pos 7 -> 1.98 ms); then GAP.
REQ-024 Disabled channel: servo[slot] stays low for the whole slot; slot timing is unchanged.
REQ-025 GAP: output low until SLOT_TICKS ticks have elapsed since slot start; then next slot's PULSE, or REST after slot 3.
REQ-026 REST: all outputs low until the frame counter wraps; then LOAD.
REQ-027 At most one servo bit SHALL be high in any cycle.
REQ-028 Width arithmetic SHALL be at least 8 bits wide with no truncation (max 198 < SLOT_TICKS).
REQ-029 Slot n pulse SHALL rise exactly n*SLOT_TICKS ticks after the frame start, within +/-1 clk cycle.

Reset
REQ-030 While rst is high at a clk edge: servo=4'b0000, frame_start=0, pending=0, state=IDLE, prescaler and frame counter=0.
REQ-031 Reset values for all shadow and active registers: pos=0, ena=0.
REQ-032 Reset asserted mid-pulse SHALL drive the output low on the next clk edge, with no partial pulse resuming afterward.

Verification (TICK_DIV=2, SLOT_TICKS=250, FRAME_TICKS=2000)
REQ-033 Reset, then no writes for 3 frames -> servo stays 0; frame_start pulses every 4000 clk cycles.
REQ-034 Write ch0 pos=0 ena=1 -> pending=1 until next frame_start; servo[0] high 200 clk cycles each frame.
REQ-035 Write ch2 pos=7 ena=1 mid-frame -> no change in the current frame; next frame servo[2] rises 1000 clk cycles after frame_start and stays high 396 cycles.
REQ-036 Two writes to ch1 (pos=3, then pos=5) in one frame -> next frame width = 170 ticks = 340 clk cycles.
REQ-037 Write on the exact LOAD cycle -> applied one frame later; pending remains 1 through the intervening frame.
REQ-038 rst pulsed during the ch0 pulse -> servo[0]=0 the next cycle; all channels disabled afterward until rewritten.

Source files
------------

// File: rtl/servo_frame_sched.sv
// -----------------------------------------------------------------------------
// servo_frame_sched
//
// Four-channel hobby-servo PWM frame scheduler. A prescaler divides clk into
// timing ticks. A frame counter divides those ticks into servo frames. Each
// frame is split into four equal slots, one per channel. At the start of a
// slot the owning channel's output goes high for W = 100 + 14*pos ticks. The
// output then stays low for the rest of the slot. After slot 3 every output
// stays low until the frame counter wraps.
//
// Configuration is double-buffered. A write lands in a per-channel shadow
// register. The shadow is copied to the active register only in the single
// LOAD cycle at the frame boundary, so a write can never reshape a pulse that
// is already in progress.
//
// Ports
//   clk         system clock, single clock domain
//   rst         synchronous, active-high reset
//   wr_en       one-cycle configuration write strobe
//   wr_ch       channel (0..3) addressed by the write
//   wr_pos      position code (0..7) for that channel
//   wr_ena      channel enable written together with the position
//   servo       per-channel PWM outputs, registered; bit n drives servo n
//   frame_start one-cycle pulse on the first cycle of each frame
//   pending     high while a written configuration has not yet been applied
// -----------------------------------------------------------------------------
module servo_frame_sched #(
  parameter int TICK_DIV    = 500,
  parameter int SLOT_TICKS  = 250,
  parameter int FRAME_TICKS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_ch,
  input  logic [2:0] wr_pos,
  input  logic       wr_ena,
  output logic [3:0] servo,
  output logic       frame_start,
  output logic       pending
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FRAME_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  // The slot tick counter also holds pulse widths of up to 198, so it is
  // never narrower than 8 bits.
  localparam int SLOT_CW = $clog2(SLOT_TICKS + 1);
  localparam int SLOT_W  = (SLOT_CW > 8) ? SLOT_CW : 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    REST  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [PRESC_W-1:0]  r_presc;
  logic                w_tick;
  logic                r_tick_d;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic                w_frame_wrap;

  logic [1:0]          r_slot;
  logic [1:0]          w_slot_next;
  logic [SLOT_W-1:0]   r_slot_tick;
  logic [SLOT_W-1:0]   w_slot_tick_next;
  logic [SLOT_W-1:0]   w_slot_tick_inc;
  logic [7:0]          w_width;

  logic [2:0]          r_sh_pos  [4];
  logic [3:0]          r_sh_ena;
  logic [2:0]          r_act_pos [4];
  logic [3:0]          r_act_ena;

  logic [3:0]          w_servo_next;
  logic                w_frame_start_next;
  logic [3:0]          r_servo;
  logic                r_frame_start;
  logic                r_pending;

  // ---------------------------------------------------------------------------
  // Prescaler: counts 0..TICK_DIV-1. The tick is asserted on the wrap cycle.
  // ---------------------------------------------------------------------------
  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  // NOTE: sequential state is written with non-blocking assignments. Every
  // flop then samples the values from before the edge, whatever order the
  // blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc  <= '0;
      r_tick_d <= 1'b0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + PRESC_W'(1);
      r_tick_d <= w_tick;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter: 0..FRAME_TICKS-1, one step per tick. It is held at 0 in IDLE
  // so that the first frame is aligned to the first tick after reset.
  // ---------------------------------------------------------------------------
  assign w_frame_wrap = w_tick && (r_frame_cnt == FRAME_W'(FRAME_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state == IDLE) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + FRAME_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and active configuration.
  // A write in the LOAD cycle updates the shadow, while the active register
  // picks up the shadow value from before that write. The write is therefore
  // applied at the following frame start.
  // ---------------------------------------------------------------------------
  // NOTE: this storage is plain flip-flops with an explicit reset, not an
  // inferred RAM. A freshly reset block therefore holds every channel
  // disabled, rather than holding undefined contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_sh_pos[i] <= 3'd0;
      end
      r_sh_ena <= 4'b0000;
    end else if (wr_en) begin
      r_sh_pos[wr_ch] <= wr_pos;
      r_sh_ena[wr_ch] <= wr_ena;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_act_pos[i] <= 3'd0;
      end
      r_act_ena <= 4'b0000;
    end else if (r_state == LOAD) begin
      r_act_pos <= r_sh_pos;
      r_act_ena <= r_sh_ena;
    end
  end

  // A write coinciding with LOAD keeps pending set, because the copy taken in
  // that cycle does not include the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (wr_en) begin
      r_pending <= 1'b1;
    end else if (r_state == LOAD) begin
      r_pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot sequencing.
  // LOAD takes one clk cycle out of the first tick period. Slot timing is
  // therefore counted on the cycle after each tick (r_tick_d). This makes each
  // pulse exactly W*TICK_DIV clk cycles long. Every slot edge lands one cycle
  // after its nominal position, measured from frame_start.
  // ---------------------------------------------------------------------------
  assign w_width         = 8'd100 + ({5'd0, r_act_pos[r_slot]} * 8'd14);
  assign w_slot_tick_inc = r_slot_tick + SLOT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_slot      <= 2'd0;
      r_slot_tick <= '0;
    end else begin
      r_state     <= w_state_next;
      r_slot      <= w_slot_next;
      r_slot_tick <= w_slot_tick_next;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default value first. No path
    // through the case can then leave a signal unassigned, so no latch is
    // inferred.
    w_state_next       = r_state;
    w_slot_next        = r_slot;
    w_slot_tick_next   = r_slot_tick;
    w_servo_next       = 4'b0000;
    w_frame_start_next = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_next = LOAD;
        end
      end

      LOAD: begin
        w_frame_start_next = 1'b1;
        w_slot_next        = 2'd0;
        w_slot_tick_next   = '0;
        w_state_next       = PULSE;
      end

      PULSE: begin
        // A disabled channel still walks through PULSE, so the slot timing
        // is identical whether or not the channel drives its output.
        w_servo_next[r_slot] = r_act_ena[r_slot];
        if (r_tick_d) begin
          w_slot_tick_next = w_slot_tick_inc;
          if (w_slot_tick_inc == SLOT_W'(w_width)) begin
            w_state_next = GAP;
          end
        end
      end

      GAP: begin
        if (r_tick_d) begin
          w_slot_tick_next = w_slot_tick_inc;
          if (w_slot_tick_inc == SLOT_W'(SLOT_TICKS)) begin
            w_slot_tick_next = '0;
            if (r_slot == 2'd3) begin
              w_state_next = REST;
            end else begin
              w_slot_next  = r_slot + 2'd1;
              w_state_next = PULSE;
            end
          end
        end
      end

      REST: begin
        if (w_frame_wrap) begin
          w_state_next = LOAD;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. The pins are driven straight from flops, so they are
  // glitch-free. servo and frame_start share the same one-cycle lag, which
  // keeps their relative timing exact.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_servo       <= 4'b0000;
      r_frame_start <= 1'b0;
    end else begin
      r_servo       <= w_servo_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  assign servo       = r_servo;
  assign frame_start = r_frame_start;
  assign pending     = r_pending;

endmodule
